// File: rtl/data_mem_responder.sv
// Memory-side responder for the LSU/D-cache request protocol: one outstanding read or write,
// fixed programmable latency, single-cycle response pulse and a one-cycle cooldown.
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LATENCY    = 3,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic [3:0]  mem_byte_en_i,
  output logic        mem_resp_o,
  output logic [31:0] mem_data_o,
  output logic        mem_err_o
);

  localparam int unsigned Words   = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  LoadCnt = 4'(LATENCY - 1);
  localparam bit          Single  = (LATENCY == 1);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("data_mem_responder: LATENCY must be in 1..15");
  end
  if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
    $error("data_mem_responder: BASE_ADDR must be 4-byte aligned");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StResp, StCool} state_e;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic                    write_q;
  logic                    err_q;
  logic                    inr_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [31:0]             wdata_q;
  logic [3:0]              be_q;

  logic [31:0]             mem [Words];

  logic [31:0]             offset;
  logic                    cur_inr;
  logic [ADDR_WIDTH-1:0]   cur_idx;
  logic                    req;
  logic                    from_idle;
  logic                    enter_resp;
  logic                    sel_write;
  logic                    sel_inr;
  logic                    sel_err;
  logic [ADDR_WIDTH-1:0]   sel_idx;
  logic [31:0]             sel_data;
  logic [3:0]              sel_be;
  logic [31:0]             resp_data;
  logic                    commit;

  assign offset  = mem_addr_i - BASE_ADDR;
  assign cur_inr = (mem_addr_i >= BASE_ADDR) && ((offset >> (ADDR_WIDTH + 2)) == 32'd0);
  assign cur_idx = offset[ADDR_WIDTH+1:2];
  assign req     = mem_read_i | mem_write_i;

  // With LATENCY=1 the response is launched straight from IDLE, so the live inputs are used
  // instead of the (not yet loaded) latched copy.
  assign from_idle  = (state_q == StIdle);
  assign enter_resp = (from_idle && req && Single) || (state_q == StBusy && cnt_q == 4'd1);

  always_comb begin
    sel_write = write_q;
    sel_inr   = inr_q;
    sel_err   = err_q;
    sel_idx   = idx_q;
    sel_data  = wdata_q;
    sel_be    = be_q;
    if (from_idle) begin
      sel_write = mem_write_i;
      sel_inr   = cur_inr;
      sel_err   = (mem_read_i & mem_write_i) | ~cur_inr;
      sel_idx   = cur_idx;
      sel_data  = mem_data_i;
      sel_be    = mem_byte_en_i;
    end
  end

  assign resp_data = (!sel_write && sel_inr) ? mem[sel_idx] : 32'd0;
  assign commit    = enter_resp && sel_write && sel_inr && !rst;

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (commit && sel_be[b]) begin
        mem[sel_idx][8*b +: 8] <= sel_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      inr_q      <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= 32'd0;
      be_q       <= 4'd0;
      mem_resp_o <= 1'b0;
      mem_data_o <= 32'd0;
      mem_err_o  <= 1'b0;
    end else begin
      mem_resp_o <= 1'b0;
      mem_err_o  <= 1'b0;
      if (enter_resp) begin
        mem_resp_o <= 1'b1;
        mem_err_o  <= sel_err;
        mem_data_o <= resp_data;
      end
      case (state_q)
        StIdle: begin
          if (req) begin
            write_q <= mem_write_i;
            err_q   <= (mem_read_i & mem_write_i) | ~cur_inr;
            inr_q   <= cur_inr;
            idx_q   <= cur_idx;
            wdata_q <= mem_data_i;
            be_q    <= mem_byte_en_i;
            cnt_q   <= LoadCnt;
            state_q <= Single ? StResp : StBusy;
          end
        end
        StBusy: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= StResp;
        end
        StResp:  state_q <= StCool;
        StCool:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
